top_if_wrapper: RTL and testbench

TOP_IF_WRAPPER -- requirements
Module: top_if_wrapper

---
 rtl/top_if_wrapper_pkg.sv | 38 +++
 rtl/top_if_wrapper_if.sv | 25 ++
 rtl/top_if_wrapper_rr_arbiter.sv | 48 ++++
 rtl/top_if_wrapper.sv | 108 ++++++++++
 tb/tb_top_if_wrapper.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/top_if_wrapper_pkg.sv
// rtl/top_if_wrapper_pkg.sv - shared constants, beat type and round-robin search helper
package top_if_wrapper_pkg;

  localparam int N_CH   = 8;
  localparam int DATA_W = 32;
  localparam int CH_W   = 3;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  typedef struct packed {
    logic            found;
    logic [CH_W-1:0] idx;
  } pick_t;

  // Walk offsets from farthest to nearest so the channel closest after last_ptr wins.
  function automatic pick_t rr_pick(input logic [N_CH-1:0] req, input logic [CH_W-1:0] last_ptr);
    pick_t           p;
    logic [CH_W-1:0] idx;
    p = '0;
    for (int i = N_CH; i >= 1; i--) begin
      idx = last_ptr + CH_W'(i);
      if (req[idx]) begin
        p.found = 1'b1;
        p.idx   = idx;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/top_if_wrapper_if.sv
// rtl/top_if_wrapper_if.sv - packet stream interfaces for the merge inputs and output
interface input_if;
  import top_if_wrapper_pkg::*;

  logic              valid;
  logic [DATA_W-1:0] data;
  logic              last;
  logic              ready;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

interface output_if;
  import top_if_wrapper_pkg::*;

  logic              valid;
  logic [DATA_W-1:0] data;
  logic              last;
  logic [CH_W-1:0]   ch_id;
  logic              ready;

  modport master (output valid, data, last, ch_id, input ready);
  modport slave  (input valid, data, last, ch_id, output ready);
endinterface

// File: rtl/top_if_wrapper_rr_arbiter.sv
// rtl/top_if_wrapper_rr_arbiter.sv - packet-locked round-robin arbiter over 8 requests
module rr_arbiter
  import top_if_wrapper_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] req,
  input  logic            xfer,
  input  logic            xfer_last,
  output logic [N_CH-1:0] grant_oh,
  output logic [CH_W-1:0] grant_idx,
  output logic            grant_vld
);

  arb_state_t      state;
  logic [CH_W-1:0] lock_idx;
  logic [CH_W-1:0] last_ptr;
  pick_t           pick;

  // Unlocked grants are combinational so a released packet hands over without a bubble.
  always_comb begin
    pick      = rr_pick(req, last_ptr);
    grant_idx = pick.idx;
    grant_vld = pick.found;
    if (state == ARB_LOCKED) begin
      grant_idx = lock_idx;
      grant_vld = 1'b1;
    end
    grant_oh = grant_vld ? (N_CH'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ARB_IDLE;
      lock_idx <= '0;
      last_ptr <= CH_W'(N_CH - 1);
    end else if (xfer) begin
      if (xfer_last) begin
        state    <= ARB_IDLE;
        last_ptr <= grant_idx;
      end else begin
        state    <= ARB_LOCKED;
        lock_idx <= grant_idx;
      end
    end
  end

endmodule

// File: rtl/top_if_wrapper.sv
// rtl/top_if_wrapper.sv - merges 8 packet streams onto one registered output, round-robin per packet
module top_if_wrapper #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 32
) (
  input  logic     clk,
  input  logic     reset_n,
  input_if.slave   _if_i_ch0,
  input_if.slave   _if_i_ch1,
  input_if.slave   _if_i_ch2,
  input_if.slave   _if_i_ch3,
  input_if.slave   _if_i_ch4,
  input_if.slave   _if_i_ch5,
  input_if.slave   _if_i_ch6,
  input_if.slave   _if_i_ch7,
  output_if.master _if_o
);

  localparam int CH_W = top_if_wrapper_pkg::CH_W;

  logic [N_CH-1:0]   in_valid;
  logic [N_CH-1:0]   in_last;
  logic [N_CH-1:0]   in_ready;
  logic [DATA_W-1:0] in_data [N_CH];

  logic [N_CH-1:0]   grant_oh;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_vld;
  logic              can_take;
  logic              accept;

  top_if_wrapper_pkg::beat_t out_q;
  logic                      out_valid;
  logic [CH_W-1:0]           out_ch;

  assign in_valid[0] = _if_i_ch0.valid;
  assign in_valid[1] = _if_i_ch1.valid;
  assign in_valid[2] = _if_i_ch2.valid;
  assign in_valid[3] = _if_i_ch3.valid;
  assign in_valid[4] = _if_i_ch4.valid;
  assign in_valid[5] = _if_i_ch5.valid;
  assign in_valid[6] = _if_i_ch6.valid;
  assign in_valid[7] = _if_i_ch7.valid;

  assign in_last[0] = _if_i_ch0.last;
  assign in_last[1] = _if_i_ch1.last;
  assign in_last[2] = _if_i_ch2.last;
  assign in_last[3] = _if_i_ch3.last;
  assign in_last[4] = _if_i_ch4.last;
  assign in_last[5] = _if_i_ch5.last;
  assign in_last[6] = _if_i_ch6.last;
  assign in_last[7] = _if_i_ch7.last;

  assign in_data[0] = _if_i_ch0.data;
  assign in_data[1] = _if_i_ch1.data;
  assign in_data[2] = _if_i_ch2.data;
  assign in_data[3] = _if_i_ch3.data;
  assign in_data[4] = _if_i_ch4.data;
  assign in_data[5] = _if_i_ch5.data;
  assign in_data[6] = _if_i_ch6.data;
  assign in_data[7] = _if_i_ch7.data;

  assign _if_i_ch0.ready = in_ready[0];
  assign _if_i_ch1.ready = in_ready[1];
  assign _if_i_ch2.ready = in_ready[2];
  assign _if_i_ch3.ready = in_ready[3];
  assign _if_i_ch4.ready = in_ready[4];
  assign _if_i_ch5.ready = in_ready[5];
  assign _if_i_ch6.ready = in_ready[6];
  assign _if_i_ch7.ready = in_ready[7];

  // reset_n gates ready so nothing is offered while reset is held.
  assign can_take = reset_n & (~out_valid | _if_o.ready);
  assign in_ready = can_take ? grant_oh : '0;
  assign accept   = can_take & grant_vld & in_valid[grant_idx];

  rr_arbiter u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (in_valid),
    .xfer      (accept),
    .xfer_last (in_last[grant_idx]),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      out_ch    <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_q.data <= in_data[grant_idx];
      out_q.last <= in_last[grant_idx];
      out_ch     <= grant_idx;
    end else if (_if_o.ready) begin
      out_valid <= 1'b0;
    end
  end

  assign _if_o.valid = out_valid;
  assign _if_o.data  = out_q.data;
  assign _if_o.last  = out_q.last;
  assign _if_o.ch_id = out_ch;

endmodule

// File: tb/tb_top_if_wrapper.sv
// tb/tb_top_if_wrapper.sv - table-driven bench for the 8-to-1 packet merge
module tb_top_if_wrapper;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  tb_valid;
  logic [7:0]  tb_last;
  logic [7:0]  tb_ready;
  logic [31:0] tb_data [8];
  logic        tb_oready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  input_if  in_if [8] ();
  output_if out_if ();

  genvar g;
  generate
    for (g = 0; g < 8; g++) begin : g_ch
      assign in_if[g].valid = tb_valid[g];
      assign in_if[g].last  = tb_last[g];
      assign in_if[g].data  = tb_data[g];
      assign tb_ready[g]    = in_if[g].ready;
    end
  endgenerate

  assign out_if.ready = tb_oready;

  top_if_wrapper #(.N_CH(8), .DATA_W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    ._if_i_ch0 (in_if[0]),
    ._if_i_ch1 (in_if[1]),
    ._if_i_ch2 (in_if[2]),
    ._if_i_ch3 (in_if[3]),
    ._if_i_ch4 (in_if[4]),
    ._if_i_ch5 (in_if[5]),
    ._if_i_ch6 (in_if[6]),
    ._if_i_ch7 (in_if[7]),
    ._if_o     (out_if)
  );

  typedef struct {
    logic [7:0]  valid;
    logic [7:0]  last;
    logic [31:0] dbase;
    logic        oready;
    logic [7:0]  exp_ready;
    logic        exp_ov;
    logic [2:0]  exp_ch;
    logic [31:0] exp_data;
    logic        exp_last;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] v, input logic [7:0] l, input logic [31:0] dbase, input logic ordy);
    tb_valid  = v;
    tb_last   = l;
    tb_oready = ordy;
    for (int c = 0; c < 8; c++) tb_data[c] = dbase + 32'(c);
  endtask

  task automatic check_out(input string tag, input logic ov, input logic [2:0] ch,
                           input logic [31:0] d, input logic l);
    check({tag, " valid"}, 32'(out_if.valid), 32'(ov));
    if (ov) begin
      check({tag, " ch_id"}, 32'(out_if.ch_id), 32'(ch));
      check({tag, " data"},  out_if.data, d);
      check({tag, " last"},  32'(out_if.last), 32'(l));
    end
  endtask

  function automatic void add(input logic [7:0] v, input logic [7:0] l, input logic [31:0] db,
                              input logic [7:0] er, input logic ov, input logic [2:0] ch,
                              input logic [31:0] d, input logic el);
    vec_t x;
    x.valid = v; x.last = l; x.dbase = db; x.oready = 1'b1;
    x.exp_ready = er; x.exp_ov = ov; x.exp_ch = ch; x.exp_data = d; x.exp_last = el;
    vecs.push_back(x);
  endfunction

  initial begin
    // idle
    add(8'h00, 8'h00, 32'h0,        8'h00, 1'b0, 3'd0, 32'h0,        1'b0);
    // all eight channels with single-beat packets
    add(8'hFF, 8'hFF, 32'h100,      8'h01, 1'b1, 3'd0, 32'h100,      1'b1);
    add(8'hFE, 8'hFE, 32'h100,      8'h02, 1'b1, 3'd1, 32'h101,      1'b1);
    add(8'hFC, 8'hFC, 32'h100,      8'h04, 1'b1, 3'd2, 32'h102,      1'b1);
    add(8'hF8, 8'hF8, 32'h100,      8'h08, 1'b1, 3'd3, 32'h103,      1'b1);
    add(8'hF0, 8'hF0, 32'h100,      8'h10, 1'b1, 3'd4, 32'h104,      1'b1);
    add(8'hE0, 8'hE0, 32'h100,      8'h20, 1'b1, 3'd5, 32'h105,      1'b1);
    add(8'hC0, 8'hC0, 32'h100,      8'h40, 1'b1, 3'd6, 32'h106,      1'b1);
    add(8'h80, 8'h80, 32'h100,      8'h80, 1'b1, 3'd7, 32'h107,      1'b1);
    // ch1 3-beat packet while ch2 waits
    add(8'h06, 8'h04, 32'h10,       8'h02, 1'b1, 3'd1, 32'h11,       1'b0);
    add(8'h06, 8'h04, 32'h11,       8'h02, 1'b1, 3'd1, 32'h12,       1'b0);
    add(8'h06, 8'h06, 32'h12,       8'h02, 1'b1, 3'd1, 32'h13,       1'b1);
    add(8'h04, 8'h04, 32'h30,       8'h04, 1'b1, 3'd2, 32'h32,       1'b1);
    // ch5 drops valid mid-packet; lock holds against ch0
    add(8'h20, 8'h00, 32'h50,       8'h20, 1'b1, 3'd5, 32'h55,       1'b0);
    add(8'h01, 8'h01, 32'h50,       8'h20, 1'b0, 3'd0, 32'h0,        1'b0);
    add(8'h21, 8'h21, 32'h60,       8'h20, 1'b1, 3'd5, 32'h65,       1'b1);
    // ch7 then wrap to ch0 ahead of ch6
    add(8'h81, 8'h81, 32'h70,       8'h80, 1'b1, 3'd7, 32'h77,       1'b1);
    add(8'h41, 8'h41, 32'h80,       8'h01, 1'b1, 3'd0, 32'h80,       1'b1);
    add(8'h40, 8'h40, 32'h80,       8'h40, 1'b1, 3'd6, 32'h86,       1'b1);
    add(8'h08, 8'h08, 32'hDEADBEEC, 8'h08, 1'b1, 3'd3, 32'hDEADBEEF, 1'b1);
    add(8'h00, 8'h00, 32'h0,        8'h00, 1'b0, 3'd0, 32'h0,        1'b0);

    // reset state, with every channel requesting
    reset_n = 1'b0;
    drive(8'hFF, 8'hFF, 32'h0, 1'b1);
    #2;
    check("reset ready", 32'(tb_ready), 32'h0);
    check("reset valid", 32'(out_if.valid), 32'h0);
    check("reset data",  out_if.data, 32'h0);
    check("reset last",  32'(out_if.last), 32'h0);
    check("reset ch_id", 32'(out_if.ch_id), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    drive(8'h00, 8'h00, 32'h0, 1'b1);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].last, vecs[i].dbase, vecs[i].oready);
      @(negedge clk);
      check($sformatf("row%0d ready", i), 32'(tb_ready), 32'(vecs[i].exp_ready));
      @(posedge clk); #1;
      check_out($sformatf("row%0d", i), vecs[i].exp_ov, vecs[i].exp_ch, vecs[i].exp_data, vecs[i].exp_last);
    end

    // backpressure: 0xA5A5A5A5 held for 4 cycles while ch3 waits
    drive(8'h04, 8'h04, 32'h0, 1'b0);
    tb_data[2] = 32'hA5A5A5A5;
    @(negedge clk);
    check("bp accept ready", 32'(tb_ready), 32'h04);
    @(posedge clk); #1;
    check_out("bp load", 1'b1, 3'd2, 32'hA5A5A5A5, 1'b1);
    drive(8'h08, 8'h08, 32'h0, 1'b0);
    tb_data[3] = 32'h33;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d ready", k), 32'(tb_ready), 32'h00);
      @(posedge clk); #1;
      check_out($sformatf("bp%0d hold", k), 1'b1, 3'd2, 32'hA5A5A5A5, 1'b1);
    end
    tb_oready = 1'b1;
    @(negedge clk);
    check("bp release ready", 32'(tb_ready), 32'h08);
    @(posedge clk); #1;
    check_out("bp release", 1'b1, 3'd3, 32'h33, 1'b1);
    drive(8'h00, 8'h00, 32'h0, 1'b1);
    @(posedge clk); #1;
    check_out("bp drain", 1'b0, 3'd0, 32'h0, 1'b0);

    // reset mid-packet on ch4
    drive(8'h10, 8'h00, 32'h40, 1'b1);
    @(posedge clk); #1;
    check_out("rst first beat", 1'b1, 3'd4, 32'h44, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst async valid", 32'(out_if.valid), 32'h0);
    check("rst async data",  out_if.data, 32'h0);
    check("rst async ch_id", 32'(out_if.ch_id), 32'h0);
    check("rst async last",  32'(out_if.last), 32'h0);
    check("rst async ready", 32'(tb_ready), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    drive(8'h00, 8'h00, 32'h0, 1'b1);
    reset_n = 1'b1;
    drive(8'hFF, 8'hFF, 32'h900, 1'b1);
    @(negedge clk);
    check("post-rst ready", 32'(tb_ready), 32'h01);
    @(posedge clk); #1;
    check_out("post-rst", 1'b1, 3'd0, 32'h900, 1'b1);
    drive(8'hFE, 8'hFE, 32'h900, 1'b1);
    @(posedge clk); #1;
    check_out("post-rst next", 1'b1, 3'd1, 32'h901, 1'b1);
    drive(8'h00, 8'h00, 32'h0, 1'b1);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
